fifo_wr_arbiter: RTL

- Round-robin burst arbiter that shares the single write port of one FIFO instance among N_REQ producers in the write-clock domain.
- Consumes the FIFO's wr_request (space available) and drives its wr_valid/data_in.
- Returns a per-requester accept strobe so each producer advances its own data.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers; optional counters under FIFO_WR_ARB_STATS_EN.
// Latency: ack is combinational, the accepted word appears on fifo_wr_valid/fifo_data_in one cycle later; one idle cycle between bursts.
// Backpressure: fifo_wr_request=0 stalls the owner (no ack, burst count held) while it keeps the port.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  input  logic                      fifo_wr_request,
  output logic                      fifo_wr_valid,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [2:0]                owner,
  output logic                      busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic [2:0]                stat_sel,
  output logic [15:0]               stat_words,
  output logic [15:0]               stat_stall
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] CNT_LAST = 8'(BURST_MAX - 1);
  localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [7:0]          burst_cnt_q, burst_cnt_d;
  logic                fifo_wr_valid_q, fifo_wr_valid_d;
  logic [DATA_W-1:0]   fifo_data_in_q, fifo_data_in_d;

  logic                rr_found;
  logic [PTR_W-1:0]    rr_idx;
  logic [PTR_W-1:0]    rr_cand;
  logic                xfer;
  logic [PTR_W-1:0]    ptr_after_owner;
  logic [DATA_W-1:0]   owner_data;

  // First requester at or after ptr, wrapping past N_REQ-1.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_cand  = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      rr_cand = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign owner_data      = req_data[int'(owner_q)*DATA_W +: DATA_W];
  assign xfer            = (state_q == ST_BURST) && req[owner_q] && fifo_wr_request;
  assign ptr_after_owner = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;

  always_comb begin
    ack = '0;
    if (xfer) begin
      ack[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    burst_cnt_d     = burst_cnt_q;
    fifo_wr_valid_d = 1'b0;
    fifo_data_in_d  = fifo_data_in_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          owner_d     = rr_idx;
          burst_cnt_d = '0;
          state_d     = ST_BURST;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          fifo_data_in_d  = owner_data;
          fifo_wr_valid_d = 1'b1;
          burst_cnt_d     = burst_cnt_q + 8'd1;
          if (burst_cnt_q == CNT_LAST) begin
            ptr_d   = ptr_after_owner;
            state_d = ST_IDLE;
          end
        end else if (!req[owner_q]) begin
          // Owner released; a stalled owner (req high, no space) keeps the port.
          ptr_d   = ptr_after_owner;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      owner_q         <= '0;
      burst_cnt_q     <= '0;
      fifo_wr_valid_q <= 1'b0;
      fifo_data_in_q  <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      owner_q         <= owner_d;
      burst_cnt_q     <= burst_cnt_d;
      fifo_wr_valid_q <= fifo_wr_valid_d;
      fifo_data_in_q  <= fifo_data_in_d;
    end
  end

  assign fifo_wr_valid = fifo_wr_valid_q;
  assign fifo_data_in  = fifo_data_in_q;
  assign owner         = 3'(owner_q);
  assign busy          = (state_q == ST_BURST);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] stat_words_q, stat_words_d;
  logic [15:0]            stat_stall_q, stat_stall_d;

  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (ack[i] && (stat_words_q[i] != 16'hFFFF)) begin
        stat_words_d[i] = stat_words_q[i] + 16'd1;
      end
    end
    if ((state_q == ST_BURST) && req[owner_q] && !fifo_wr_request
        && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  always_comb begin
    stat_words = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (stat_sel == 3'(i)) begin
        stat_words = stat_words_q[i];
      end
    end
  end

  assign stat_stall = stat_stall_q;
`endif

endmodule
